dma_read_burst_ctrl: RTL

Upstream producer for the read-data fifo. It accepts one transfer command (start address, word count) and splits it into memory read bursts. Each burst is capped by MAX_BURST and never crosses a BOUNDARY_BYTES address boundary. Returned read data is written into the fifo. A credit counter tracks fifo space so that wr_en is never asserted into a full fifo.

---
 rtl/dma_pkg.sv | 36 +++
 rtl/dma_credit_counter.sv | 34 +++
 rtl/dma_read_burst_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA read-burst controller:
// FSM state encoding, default-derived constants and the burst-length rule.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CALC      = 2'd1,
    ST_REQ       = 2'd2,
    ST_WAIT_DATA = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_BURST_BITS = 4;
  localparam int unsigned BPW            = DEF_DATA_WIDTH / 8;
  localparam int unsigned MAX_BURST      = 2 ** DEF_BURST_BITS;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned max_burst_of(input int unsigned burst_bits);
    return 32'd1 << burst_bits;
  endfunction

  // Smallest of words left, the burst cap and the words before the next boundary.
  function automatic int unsigned burst_len(input int unsigned remaining,
                                            input int unsigned max_burst,
                                            input int unsigned to_boundary);
    int unsigned m;
    m = remaining;
    if (max_burst < m) m = max_burst;
    if (to_boundary < m) m = to_boundary;
    return m;
  endfunction

endpackage

// File: rtl/dma_credit_counter.sv
// Tracks free fifo slots: words are taken when a burst is issued and given
// back one at a time as the consumer pops the fifo.
module dma_credit_counter #(
  parameter int unsigned FIFO_BITS_DEPTH = 8,
  parameter int unsigned AMT_WIDTH       = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 take,
  input  logic [AMT_WIDTH-1:0] take_amt,
  input  logic                 give,
  input  logic [AMT_WIDTH-1:0] need,
  output logic                 has_space
);

  localparam int unsigned CW = FIFO_BITS_DEPTH + 1;
  localparam logic [CW-1:0] CAPACITY = {1'b1, {FIFO_BITS_DEPTH{1'b0}}};

  logic [CW-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    if (take) credit_d = credit_d - CW'(take_amt);
    if (give) credit_d = credit_d + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) credit_q <= CAPACITY;
    else       credit_q <= credit_d;
  end

  assign has_space = 32'(credit_q) >= 32'(need);

endmodule

// File: rtl/dma_read_burst_ctrl.sv
// Splits one (address, length) transfer into capped, boundary-safe read bursts
// and forwards returned words into the read-data fifo without overrunning it.
module dma_read_burst_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned BURST_BITS      = DEF_BURST_BITS,
  parameter int unsigned BOUNDARY_BYTES  = 4096,
  parameter int unsigned FIFO_BITS_DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [BURST_BITS:0]   req_len,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_rd_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned WORD_BYTES = bytes_per_word(DATA_WIDTH);
  localparam int unsigned BURST_CAP  = max_burst_of(BURST_BITS);
  localparam int unsigned BOUND_BITS = $clog2(BOUNDARY_BYTES);
  localparam int unsigned BLEN_W     = BURST_BITS + 1;
  localparam int unsigned OUT_W      = FIFO_BITS_DEPTH + 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
  logic [BLEN_W-1:0]       blen_q, blen_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;
  logic                    fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_WIDTH-1:0]   fifo_din_q, fifo_din_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [31:0]             offset_c, to_boundary_c;
  logic [BLEN_W-1:0]       blen_c;
  logic                    req_hs, rsp_accept, has_space;

  assign req_hs     = (state_q == ST_REQ) && req_ready;
  assign rsp_accept = rsp_valid && (outstanding_q != '0);

  dma_credit_counter #(
    .FIFO_BITS_DEPTH(FIFO_BITS_DEPTH),
    .AMT_WIDTH      (BLEN_W)
  ) u_credit (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .take     (req_hs),
    .take_amt (blen_q),
    .give     (fifo_rd_en),
    .need     (blen_c),
    .has_space(has_space)
  );

  // Burst length for the current address; evaluated every cycle so that CALC
  // can keep re-checking credit while it waits for the consumer.
  always_comb begin
    offset_c      = 32'(addr_q[BOUND_BITS-1:0]);
    to_boundary_c = (BOUNDARY_BYTES - offset_c) / WORD_BYTES;
    blen_c        = BLEN_W'(burst_len(32'(remaining_q), BURST_CAP, to_boundary_c));
  end

  // NOTE: every _d starts from a default so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    blen_d        = blen_q;
    done_d        = 1'b0;
    fifo_wr_en_d  = rsp_accept;
    fifo_din_d    = rsp_data;
    error_d       = error_q | (rsp_valid && (outstanding_q == '0));
    outstanding_d = outstanding_q
                  + (req_hs ? OUT_W'(blen_q) : '0)
                  - (rsp_accept ? OUT_W'(1) : '0);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        blen_d = blen_c;
        if (has_space) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (req_ready) begin
          addr_d      = addr_q + ADDR_WIDTH'(blen_q) * ADDR_WIDTH'(WORD_BYTES);
          remaining_d = remaining_q - LEN_WIDTH'(blen_q);
          state_d     = (remaining_d != '0) ? ST_CALC : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (outstanding_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      blen_q        <= '0;
      outstanding_q <= '0;
      fifo_wr_en_q  <= 1'b0;
      fifo_din_q    <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      blen_q        <= blen_d;
      outstanding_q <= outstanding_d;
      fifo_wr_en_q  <= fifo_wr_en_d;
      fifo_din_q    <= fifo_din_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign req_valid  = (state_q == ST_REQ);
  assign req_addr   = addr_q;
  assign req_len    = blen_q;
  assign fifo_wr_en = fifo_wr_en_q;
  assign fifo_din   = fifo_din_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
